vc_switch_arbiter: RTL

//  Packet-level round-robin arbiter and credit-based flow controller for the router output port.

---
 rtl/vc_switch_arbiter_if.sv | 26 ++
 rtl/vc_switch_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vc_switch_arbiter_if.sv
// Handshake bundle between the per-VC input buffers, the switch arbiter and the output link.
interface vc_switch_arbiter_if #(
  parameter int NUM_VC = 2,
  parameter int DATA_W = 8
);
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic [NUM_VC*DATA_W-1:0] vc_data;
  logic [NUM_VC-1:0]        vc_valid;
  logic [NUM_VC-1:0]        vc_tail;
  logic [NUM_VC-1:0]        vc_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_tail;
  logic [VW-1:0]            out_vc;

  modport slave (
    input  vc_data, vc_valid, vc_tail,
    output vc_ready, out_data, out_valid, out_tail, out_vc
  );

  modport master (
    output vc_data, vc_valid, vc_tail,
    input  vc_ready, out_data, out_valid, out_tail, out_vc
  );
endinterface

// File: rtl/vc_switch_arbiter.sv
// Packet-level round-robin VC arbiter with credit-based flow control toward the output link.
// Optional per-VC head-flit counters are built only when SWITCH_ARB_STATS_EN is defined.
module vc_switch_arbiter #(
  parameter int NUM_VC     = 2,
  parameter int DATA_W     = 8,
  parameter int CREDIT_MAX = 4,
  localparam int CW        = $clog2(CREDIT_MAX + 1),
  localparam int VW        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vc_switch_arbiter_if.slave   bus,
  input  logic                 credit_ret,
  output logic [CW-1:0]        credits,
  output logic                 credit_err,
  output logic [NUM_VC*16-1:0] grant_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [VW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [VW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              credit_err_q, credit_err_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_tail_q, out_tail_d;
  logic [VW-1:0]     out_vc_q, out_vc_d;

  logic [VW-1:0]     winner;
  logic              found;
  logic [VW-1:0]     sel;
  logic              sel_valid;
  logic [NUM_VC-1:0] ready;
  logic              xfer;
  logic              xfer_tail;
  logic [DATA_W-1:0] xfer_data;
  int                idx;

  // Round-robin search starts one past the VC that last finished a packet.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_VC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_VC) idx = idx - NUM_VC;
      if (!found && bus.vc_valid[VW'(idx)]) begin
        winner = VW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel       = (state_q == LOCKED) ? owner_q : winner;
    sel_valid = (state_q == LOCKED) ? bus.vc_valid[owner_q] : found;
    ready     = '0;
    if (reset_n && (credits_q != '0) && sel_valid) ready[sel] = 1'b1;
    xfer      = |(bus.vc_valid & ready);
    xfer_tail = bus.vc_tail[sel];
    xfer_data = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (sel == VW'(i)) xfer_data = bus.vc_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    out_valid_d  = xfer;
    out_data_d   = xfer ? xfer_data : out_data_q;
    out_tail_d   = xfer ? xfer_tail : out_tail_q;
    out_vc_d     = xfer ? sel : out_vc_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (xfer_tail) begin
            rr_ptr_d = sel;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer && xfer_tail) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A return that coincides with a send leaves the count alone and is never an overflow.
    case ({xfer, credit_ret})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CW'(CREDIT_MAX)) credit_err_d = 1'b1;
        else                              credits_d    = credits_q + CW'(1);
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= VW'(NUM_VC - 1);
      owner_q      <= '0;
      credits_q    <= CW'(CREDIT_MAX);
      credit_err_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_tail_q   <= 1'b0;
      out_vc_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_tail_q   <= out_tail_d;
      out_vc_q     <= out_vc_d;
    end
  end

  assign bus.vc_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_vc    = out_vc_q;
  assign credits       = credits_q;
  assign credit_err    = credit_err_q;

`ifdef SWITCH_ARB_STATS_EN
  logic        head_xfer;
  logic [15:0] cnt_q [NUM_VC];
  logic [15:0] cnt_d [NUM_VC];

  // Only transfers accepted in IDLE are head flits; counters saturate rather than wrap.
  always_comb begin
    head_xfer = xfer && (state_q == IDLE);
    for (int i = 0; i < NUM_VC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (head_xfer && (sel == VW'(i)) && (cnt_q[i] != 16'hFFFF)) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_VC; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
